// File: rtl/param_sp_memory_pkg.sv
// Shared definitions for param_sp_memory: error codes and the byte-merge helper.
// Optional feature macro: PARAM_SP_MEMORY_PARITY_EN (one even-parity bit per word).
package param_sp_memory_pkg;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_RANGE  = 2'b01;
  localparam logic [1:0] ERR_UNINIT = 2'b10;
  localparam logic [1:0] ERR_PARITY = 2'b11;

  // be_merge works on a wide fixed-size word so any DATA_W up to this limit can
  // share it; callers zero-extend their operands and truncate the result.
  localparam int MERGE_MAX_W = 1024;
  localparam int MERGE_BE_W  = MERGE_MAX_W / 8;

  // Take bytes from new_word where be is set, otherwise keep old_word.
  function automatic logic [MERGE_MAX_W-1:0] be_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_BE_W-1:0]  be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/param_sp_memory_err_capture.sv
// Sticky error flag with first-error code capture and clear/set arbitration.
// A new error arriving together with a clear wins and re-arms the capture.
module sp_mem_err_capture
  import param_sp_memory_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       err_hit_i,
  input  logic [1:0] err_code_i,
  input  logic       err_clr_i,
  output logic       error_o,
  output logic [1:0] err_code_o
);

  logic       error_q;
  logic [1:0] code_q;

  // Latch the first error since the last clear; later errors are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else if (err_hit_i && (!error_q || err_clr_i)) begin
      error_q <= 1'b1;
      code_q  <= err_code_i;
    end else if (err_clr_i) begin
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end
  end

  assign error_o    = error_q;
  assign err_code_o = code_q;

endmodule

// File: rtl/param_sp_memory.sv
// Parametrised single-port RAM with byte enables, read-valid strobe, per-word
// written-valid tracking and sticky first-error capture.
// Optional feature macro: PARAM_SP_MEMORY_PARITY_EN adds one even-parity bit per
// word, generated on every write and checked on every read (error code 11).
module param_sp_memory
  import param_sp_memory_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 rd_wr,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [DATA_W/8-1:0]  wr_be,
  input  logic                 out_wr_data_en,
  input  logic                 err_clr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    out_wr_data,
  output logic                 error,
  output logic [1:0]           err_code
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  // Storage (contents survive reset) and per-word written flags (cleared by reset).
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] out_wr_data_q;

  logic              in_range;
  logic              addr_valid;
  logic              wr_req;
  logic              rd_req;
  logic              wr_do;
  logic [BE_W-1:0]   wr_be_eff;
  logic [DATA_W-1:0] wr_word_eff;
  logic              par_err;
  logic              err_hit;
  logic [1:0]        err_code_d;

  assign in_range   = {1'b0, addr} < DEPTH_C;
  assign addr_valid = in_range && valid_q[addr];
  assign wr_req     = en && rd_wr;
  assign rd_req     = en && !rd_wr;
  assign wr_do      = wr_req && in_range && (|wr_be);

  // First write to a word writes every byte: disabled bytes become zero, so the
  // memory never needs the old word for the default build.
  assign wr_be_eff   = addr_valid ? wr_be : {BE_W{1'b1}};
  assign wr_word_eff = addr_valid ? wr_data :
                       DATA_W'(be_merge('0, MERGE_MAX_W'(wr_data), MERGE_BE_W'(wr_be)));

`ifdef PARAM_SP_MEMORY_PARITY_EN
  logic              par_q [DEPTH];
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;

  assign old_word    = addr_valid ? mem_q[addr] : '0;
  assign merged_word = DATA_W'(be_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(wr_data),
                                        MERGE_BE_W'(wr_be)));
  assign par_err     = rd_req && addr_valid && ((^mem_q[addr]) != par_q[addr]);

  // Even parity of the full merged word, stored alongside each write.
  always_ff @(posedge clk) begin
    if (!reset && wr_do) par_q[addr] <= ^merged_word;
  end
`else
  assign par_err = 1'b0;
`endif

  // Byte-enabled array write; reset blocks any access in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset && wr_do) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be_eff[i]) mem_q[addr][8*i +: 8] <= wr_word_eff[8*i +: 8];
      end
    end
  end

  // Written-valid tracking per word.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_do) begin
      valid_q[addr] <= 1'b1;
    end
  end

  // Registered read port, valid strobe and write-data echo.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      out_wr_data_q <= '0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_data_q <= addr_valid ? mem_q[addr] : '0;
      if (wr_do && out_wr_data_en) out_wr_data_q <= wr_data;
    end
  end

  // Error source priority: range, then uninitialised read, then parity.
  always_comb begin
    err_hit    = 1'b0;
    err_code_d = ERR_NONE;
    if (en && !in_range) begin
      err_hit    = 1'b1;
      err_code_d = ERR_RANGE;
    end else if (rd_req && !addr_valid) begin
      err_hit    = 1'b1;
      err_code_d = ERR_UNINIT;
    end else if (par_err) begin
      err_hit    = 1'b1;
      err_code_d = ERR_PARITY;
    end
  end

  sp_mem_err_capture u_err_capture (
    .clk        (clk),
    .reset      (reset),
    .err_hit_i  (err_hit),
    .err_code_i (err_code_d),
    .err_clr_i  (err_clr),
    .error_o    (error),
    .err_code_o (err_code)
  );

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign out_wr_data = out_wr_data_q;

endmodule

// File: tb/tb_param_sp_memory.sv
// Self-checking bench for param_sp_memory (DATA_W=16, DEPTH=12, ADDR_W=4):
// directed vector table, randomized run against a reference model, and
// hand-written reset/parity sequences.
module tb_param_sp_memory;

  localparam int DW = 16;
  localparam int DP = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          rd_wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0]    wr_be = '0;
  logic          out_wr_data_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [DW-1:0] out_wr_data;
  logic          error;
  logic [1:0]    err_code;

  int tests = 0;
  int fails = 0;

  param_sp_memory #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .en(en), .rd_wr(rd_wr), .addr(addr),
    .wr_data(wr_data), .wr_be(wr_be), .out_wr_data_en(out_wr_data_en),
    .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .out_wr_data(out_wr_data), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en, rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    be;
    logic          echo, clr;
    logic [DW-1:0] e_rd;
    logic          e_rv, e_err;
    logic [1:0]    e_code;
    logic [DW-1:0] e_out;
  } vec_t;

  // Reference model state: memory contents as the spec describes them.
  logic [DW-1:0] m_mem [DP];
  bit            m_valid [DP];
  logic [DW-1:0] m_rd, m_out;
  logic          m_rv, m_err;
  logic [1:0]    m_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [DW-1:0] e_rd, input logic e_rv,
                         input logic e_err, input logic [1:0] e_code, input logic [DW-1:0] e_out);
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(e_rd));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_rv));
    chk({tag, ".error"}, 32'(error), 32'(e_err));
    chk({tag, ".err_code"}, 32'(err_code), 32'(e_code));
    chk({tag, ".out_wr_data"}, 32'(out_wr_data), 32'(e_out));
  endtask

  task automatic drive(input logic e, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] b, input logic echo,
                       input logic clr);
    en = e; rd_wr = rw; addr = a; wr_data = d; wr_be = b;
    out_wr_data_en = echo; err_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DP; i++) m_valid[i] = 0;
    m_rd = '0; m_out = '0; m_rv = 0; m_err = 0; m_code = 2'b00;
  endtask

  task automatic do_reset(input string tag);
    drive(0, 0, '0, '0, '0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk_all(tag, '0, 0, 0, 2'b00, '0);
  endtask

  // Reference behaviour for one clock edge, from the current inputs.
  task automatic model_step();
    bit         rng;
    logic [1:0] e;
    logic [DW-1:0] nw;
    rng  = (int'(addr) < DP);
    e    = 2'b00;
    m_rv = en && !rd_wr;
    if (en && !rng) e = 2'b01;
    else if (en && !rd_wr && !m_valid[addr]) e = 2'b10;
    if (en && !rd_wr) m_rd = (rng && m_valid[addr]) ? m_mem[addr] : '0;
    if (en && rd_wr && rng && wr_be != 2'b00) begin
      for (int b = 0; b < 2; b++)
        nw[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8]
                                : (m_valid[addr] ? m_mem[addr][8*b +: 8] : 8'h00);
      m_mem[addr]   = nw;
      m_valid[addr] = 1;
      if (out_wr_data_en) m_out = wr_data;
    end
    if (e != 2'b00 && (!m_err || err_clr)) begin
      m_err = 1; m_code = e;
    end else if (err_clr) begin
      m_err = 0; m_code = 2'b00;
    end
  endtask

  vec_t vecs [25];

  initial begin
    // en rw addr data be echo clr | rd rv err code out
    vecs[0]  = '{1,1,4'h0,16'hFFFF,2'b11,0,0, 16'h0000,0,0,2'b00,16'h0000};
    vecs[1]  = '{1,1,4'h1,16'h70AD,2'b11,0,0, 16'h0000,0,0,2'b00,16'h0000};
    vecs[2]  = '{1,0,4'h0,16'h0000,2'b00,0,0, 16'hFFFF,1,0,2'b00,16'h0000};
    vecs[3]  = '{1,0,4'h1,16'h0000,2'b00,0,0, 16'h70AD,1,0,2'b00,16'h0000};
    vecs[4]  = '{0,0,4'h0,16'h0000,2'b00,0,0, 16'h70AD,0,0,2'b00,16'h0000};
    vecs[5]  = '{1,1,4'h3,16'hABCD,2'b11,1,0, 16'h70AD,0,0,2'b00,16'hABCD};
    vecs[6]  = '{1,1,4'h3,16'h1200,2'b10,0,0, 16'h70AD,0,0,2'b00,16'hABCD};
    vecs[7]  = '{1,0,4'h3,16'h0000,2'b00,0,0, 16'h12CD,1,0,2'b00,16'hABCD};
    vecs[8]  = '{1,0,4'h5,16'h0000,2'b00,0,0, 16'h0000,1,1,2'b10,16'hABCD};
    vecs[9]  = '{1,0,4'hC,16'h0000,2'b00,0,0, 16'h0000,1,1,2'b10,16'hABCD};
    vecs[10] = '{1,1,4'hA,16'hAAAA,2'b11,0,0, 16'h0000,0,1,2'b10,16'hABCD};
    vecs[11] = '{1,1,4'hA,16'hAAAA,2'b11,0,0, 16'h0000,0,1,2'b10,16'hABCD};
    vecs[12] = '{1,1,4'hA,16'hAAAA,2'b11,0,0, 16'h0000,0,1,2'b10,16'hABCD};
    vecs[13] = '{1,1,4'hA,16'hAAAA,2'b11,1,0, 16'h0000,0,1,2'b10,16'hAAAA};
    vecs[14] = '{1,0,4'hA,16'h0000,2'b00,0,0, 16'hAAAA,1,1,2'b10,16'hAAAA};
    vecs[15] = '{1,0,4'hC,16'h0000,2'b00,0,0, 16'h0000,1,1,2'b10,16'hAAAA};
    vecs[16] = '{1,1,4'hF,16'h5555,2'b11,1,1, 16'h0000,0,1,2'b01,16'hAAAA};
    vecs[17] = '{0,0,4'h0,16'h0000,2'b00,0,1, 16'h0000,0,0,2'b00,16'hAAAA};
    vecs[18] = '{1,0,4'hF,16'h0000,2'b00,0,0, 16'h0000,1,1,2'b01,16'hAAAA};
    vecs[19] = '{1,1,4'h4,16'h3456,2'b01,0,0, 16'h0000,0,1,2'b01,16'hAAAA};
    vecs[20] = '{1,0,4'h4,16'h0000,2'b00,0,0, 16'h0056,1,1,2'b01,16'hAAAA};
    vecs[21] = '{1,1,4'h6,16'h1111,2'b00,1,0, 16'h0056,0,1,2'b01,16'hAAAA};
    vecs[22] = '{1,0,4'h6,16'h0000,2'b00,0,0, 16'h0000,1,1,2'b01,16'hAAAA};
    vecs[23] = '{0,0,4'h0,16'h0000,2'b00,0,1, 16'h0000,0,0,2'b00,16'hAAAA};
    vecs[24] = '{1,0,4'h6,16'h0000,2'b00,0,0, 16'h0000,1,1,2'b10,16'hAAAA};

    #2;
    do_reset("reset0");

    // Directed table.
    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].be,
            vecs[i].echo, vecs[i].clr);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_rv, vecs[i].e_err,
              vecs[i].e_code, vecs[i].e_out);
      $display("[TB] vec %0d en=%0d rw=%0d addr=%0h rd=%04h rv=%0d err=%0d code=%0d",
               i, vecs[i].en, vecs[i].rw, vecs[i].addr, rd_data, rd_valid, error, err_code);
    end

    // Randomized run against the reference model.
    do_reset("reset1");
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 15)),
            DW'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      model_step();
      step();
      chk_all($sformatf("rnd%0d", i), m_rd, m_rv, m_err, m_code, m_out);
      $display("[TB] rnd %0d en=%0d rw=%0d addr=%0h be=%0d rd=%04h rv=%0d err=%0d code=%0d",
               i, en, rd_wr, addr, wr_be, rd_data, rd_valid, error, err_code);
    end

    // Reset asserted together with a read clears everything and wins.
    do_reset("reset2");
    drive(1, 1, 4'h2, 16'h1234, 2'b11, 1, 0); step();
    chk_all("seqw", 16'h0000, 0, 0, 2'b00, 16'h1234);
    drive(1, 0, 4'h7, '0, '0, 0, 0); step();
    chk_all("sequninit", 16'h0000, 1, 1, 2'b10, 16'h1234);
    drive(1, 0, 4'h2, '0, '0, 0, 0); step();
    chk_all("seqrd", 16'h1234, 1, 1, 2'b10, 16'h1234);
    drive(1, 0, 4'h2, '0, '0, 0, 0); reset = 1'b1; step(); reset = 1'b0;
    chk_all("seqrst", 16'h0000, 0, 0, 2'b00, 16'h0000);
    $display("[TB] seq reset-mid-read rd=%04h rv=%0d err=%0d", rd_data, rd_valid, error);
    drive(1, 0, 4'h2, '0, '0, 0, 0); step();
    chk_all("seqpostrst", 16'h0000, 1, 1, 2'b10, 16'h0000);
    drive(0, 0, '0, '0, '0, 0, 0); step();
    chk("seqidle.rd_valid", 32'(rd_valid), 32'd0);

`ifdef PARAM_SP_MEMORY_PARITY_EN
    // Corrupt a stored bit behind the parity bit's back.
    drive(1, 1, 4'h2, 16'h5A5A, 2'b11, 0, 1); step();
    drive(0, 0, '0, '0, '0, 0, 1); step();
    dut.mem_q[2][0] = ~dut.mem_q[2][0];
    drive(1, 0, 4'h2, '0, '0, 0, 0); step();
    chk_all("parity", 16'h5A5B, 1, 1, 2'b11, 16'h0000);
    $display("[TB] parity rd=%04h code=%0d", rd_data, err_code);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
